muu_assoc: RTL and testbench

Parametrised cache control unit for a set-associative, write-back cache with multi-word lines. Sits between the CPU request port and the cache tag/data arrays plus the RAM interface. It decodes hit/miss per way, selects a victim, sequences per-word writeback and refill bursts against a RAM handshake, and drives the array write strobes and datapath muxes.

---
 rtl/muu_assoc.sv | 188 ++++++++++++++++++
 tb/tb_muu_assoc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muu_assoc.sv
// Set-associative write-back cache controller: hit/miss decode, victim choice, per-word
// writeback/refill bursts. Define MUU_ASSOC_WRITE_ALLOCATE_EN to allocate on write misses.
//
// state  | meaning
// IDLE   | waiting for a CPU request, array/tag inputs sampled here
// HIT_RD | read hit (or read refill done), ack
// HIT_WR | write hit (or write refill done), write word + mark dirty, ack
// WB     | writing the dirty victim line back to RAM, one word per ram_ack
// FILL   | refilling the victim line from RAM, one word per ram_ack
// WA     | write-around of a write miss straight to RAM (no allocate build only)

module muu_assoc #(
    parameter  int WAYS       = 2,
    parameter  int LINE_WORDS = 4,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int WORD_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [WAYS-1:0]   hit_way,
    input  logic [WAYS-1:0]   valid,
    input  logic [WAYS-1:0]   md,
    input  logic              ram_ack,
    output logic [WAY_W-1:0]  way_sel,
    output logic [WORD_W-1:0] word_sel,
    output logic              burst,
    output logic              chmd,
    output logic              wrt,
    output logic              wrd,
    output logic              wsel,
    output logic              tsel,
    output logic              rdram,
    output logic              wrram,
    output logic              ack
);

    typedef enum logic [2:0] {
        IDLE, HIT_RD, HIT_WR, WB, FILL
`ifndef MUU_ASSOC_WRITE_ALLOCATE_EN
        , WA
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [WAY_W-1:0]  rr_q, rr_d;
    logic              use_rr_q, use_rr_d;
    logic              is_wr_q, is_wr_d;

    logic [WAY_W-1:0]  hit_idx;
    logic [WAY_W-1:0]  vic;
    logic              vic_rr;
    logic              last_beat;

    // Lowest-index match wins when several tags match.
    always_comb begin
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = WAY_W'(i);
        end
    end

    // Prefer an empty way; fall back to the round-robin pointer only when the set is full.
    always_comb begin
        vic    = rr_q;
        vic_rr = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                vic    = WAY_W'(i);
                vic_rr = 1'b0;
            end
        end
    end

    assign last_beat = (beat_q == WORD_W'(LINE_WORDS - 1));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        way_d    = way_q;
        rr_d     = rr_q;
        use_rr_d = use_rr_q;
        is_wr_d  = is_wr_q;
        way_sel  = '0;
        word_sel = '0;
        burst    = 1'b0;
        chmd     = 1'b0;
        wrt      = 1'b0;
        wrd      = 1'b0;
        wsel     = 1'b0;
        tsel     = 1'b0;
        rdram    = 1'b0;
        wrram    = 1'b0;
        ack      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr || rd) begin
                    is_wr_d = wr;
                    beat_d  = '0;
                    if (|hit_way) begin
                        way_d   = hit_idx;
                        state_d = wr ? HIT_WR : HIT_RD;
                    end else begin
                        way_d    = vic;
                        use_rr_d = vic_rr;
                        state_d  = md[vic] ? WB : FILL;
`ifndef MUU_ASSOC_WRITE_ALLOCATE_EN
                        if (wr) state_d = WA;
`endif
                    end
                end
            end
            HIT_RD: begin
                way_sel = way_q;
                ack     = 1'b1;
                state_d = IDLE;
            end
            HIT_WR: begin
                way_sel = way_q;
                wrd     = 1'b1;
                chmd    = 1'b1;
                ack     = 1'b1;
                state_d = IDLE;
            end
            WB: begin
                wrram    = 1'b1;
                burst    = 1'b1;
                way_sel  = way_q;
                word_sel = beat_q;
                if (ram_ack) begin
                    beat_d = last_beat ? '0 : beat_q + WORD_W'(1);
                    if (last_beat) state_d = FILL;
                end
            end
            FILL: begin
                rdram    = 1'b1;
                tsel     = 1'b1;
                wsel     = 1'b1;
                burst    = 1'b1;
                way_sel  = way_q;
                word_sel = beat_q;
                wrd      = ram_ack;
                if (ram_ack) begin
                    beat_d = last_beat ? '0 : beat_q + WORD_W'(1);
                    if (last_beat) begin
                        wrt     = 1'b1;
                        state_d = is_wr_q ? HIT_WR : HIT_RD;
                        if (use_rr_q)
                            rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
                    end
                end
            end
`ifndef MUU_ASSOC_WRITE_ALLOCATE_EN
            WA: begin
                wrram = 1'b1;
                tsel  = 1'b1;
                if (ram_ack) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            way_q    <= '0;
            rr_q     <= '0;
            use_rr_q <= 1'b0;
            is_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            way_q    <= way_d;
            rr_q     <= rr_d;
            use_rr_q <= use_rr_d;
            is_wr_q  <= is_wr_d;
        end
    end

endmodule

// File: tb/tb_muu_assoc.sv
// Self-checking bench for muu_assoc (WAYS=2, LINE_WORDS=4): a transaction-level model
// produces the expected output vector of every cycle; a negedge process compares.

module tb_muu_assoc;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rd = 1'b0, wr = 1'b0, ram_ack = 1'b0;
    logic [1:0] hit_way = '0, valid = '0, md = '0;
    logic       way_sel;
    logic [1:0] word_sel;
    logic       burst, chmd, wrt, wrd, wsel, tsel, rdram, wrram, ack;

    muu_assoc #(.WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .hit_way(hit_way),
        .valid(valid), .md(md), .ram_ack(ram_ack), .way_sel(way_sel),
        .word_sel(word_sel), .burst(burst), .chmd(chmd), .wrt(wrt), .wrd(wrd),
        .wsel(wsel), .tsel(tsel), .rdram(rdram), .wrram(wrram), .ack(ack)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic        exp_en = 1'b0;
    logic [11:0] exp_vec = '0;
    int          rr_m = 0;
    logic [11:0] dut_vec;

    assign dut_vec = {way_sel, word_sel, burst, chmd, wrt, wrd, wsel, tsel, rdram, wrram, ack};

    function automatic logic [11:0] mkv(int way, int word, bit b, bit c, bit wt, bit wd,
                                        bit ws, bit ts, bit rr_, bit wr_, bit ak);
        logic [1:0] w2;
        w2 = word[1:0];
        return {way[0], w2, b, c, wt, wd, ws, ts, rr_, wr_, ak};
    endfunction

    always @(negedge clk) begin
        if (exp_en) begin
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_vec t=%0t actual=%h required=%h", $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            rd      = 1'b0;
            wr      = 1'b0;
            ram_ack = 1'b1;
            hit_way = 2'($urandom_range(0, 3));
            exp_vec = '0;
            exp_en  = 1'b1;
        end
    endtask

    // One complete CPU transaction; pat supplies ram_ack per RAM-facing cycle (must be nonzero).
    task automatic req(input bit is_wr, input bit also_rd, input logic [1:0] hw,
                       input logic [1:0] v, input logic [1:0] m, input logic [31:0] pat);
        int  k;
        int  vic;
        bit  used_rr;
        k = 0;
        next_cycle();
        rd      = !is_wr || also_rd;
        wr      = is_wr;
        hit_way = hw;
        valid   = v;
        md      = m;
        ram_ack = 1'b0;
        exp_vec = '0;
        if (hw != 2'b00) begin
            next_cycle();
            hit_way = 2'($urandom_range(0, 3));
            exp_vec = mkv(hw[0] ? 0 : 1, 0, 0, is_wr, 0, is_wr, 0, 0, 0, 0, 1);
            return;
        end
        used_rr = (v == 2'b11);
        vic     = !v[0] ? 0 : (!v[1] ? 1 : rr_m);
`ifndef MUU_ASSOC_WRITE_ALLOCATE_EN
        if (is_wr) begin
            do begin
                next_cycle();
                hit_way = 2'($urandom_range(0, 3));
                ram_ack = pat[k % 32];
                k++;
                exp_vec = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ram_ack);
            end while (!ram_ack);
            return;
        end
`endif
        if (m[vic]) begin
            for (int b = 0; b < 4; b++) begin
                do begin
                    next_cycle();
                    hit_way = 2'($urandom_range(0, 3));
                    md      = 2'($urandom_range(0, 3));
                    ram_ack = pat[k % 32];
                    k++;
                    exp_vec = mkv(vic, b, 1, 0, 0, 0, 0, 0, 0, 1, 0);
                end while (!ram_ack);
            end
        end
        for (int b = 0; b < 4; b++) begin
            do begin
                next_cycle();
                valid   = 2'($urandom_range(0, 3));
                ram_ack = pat[k % 32];
                k++;
                exp_vec = mkv(vic, b, 1, 0, ram_ack && (b == 3), ram_ack, 1, 1, 1, 0, 0);
            end while (!ram_ack);
        end
        next_cycle();
        ram_ack = pat[k % 32];
        exp_vec = mkv(vic, 0, 0, is_wr, 0, is_wr, 0, 0, 0, 0, 1);
        if (used_rr) rr_m = (rr_m + 1) % 2;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 chk("reset_outputs", 16'(dut_vec), 16'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        idle(2);

        req(0, 0, 2'b10, 2'b11, 2'b00, 32'h1);
        #1 chk("hit_rd_lit", 16'({way_sel, ack, rdram, wrram}), 16'b1100);
        req(1, 0, 2'b01, 2'b11, 2'b00, 32'h1);
        #1 chk("hit_wr_lit", 16'({wrd, chmd, wsel, way_sel, ack}), 16'b11001);
        req(0, 0, 2'b11, 2'b11, 2'b11, 32'h1);
        req(1, 1, 2'b10, 2'b01, 2'b00, 32'h1);
        idle(1);

        req(0, 0, 2'b00, 2'b01, 2'b00, 32'hFFFF_FFFF);
        #1 chk("clean_miss_ack_lit", 16'({ack, way_sel, rdram}), 16'b110);
        req(0, 0, 2'b00, 2'b11, 2'b01, 32'hB6B3_D5A7);
        req(0, 0, 2'b00, 2'b11, 2'b00, 32'hFFFF_FFFF);
        req(1, 0, 2'b00, 2'b11, 2'b10, 32'h5555_5554);
`ifndef MUU_ASSOC_WRITE_ALLOCATE_EN
        #1 chk("wa_ack_lit", 16'({wrram, ack, burst, wrd, wrt, tsel}), 16'b110001);
`else
        #1 chk("wa_alloc_lit", 16'({wrd, chmd, ack, way_sel, rdram}), 16'b11100);
`endif
        req(0, 0, 2'b00, 2'b11, 2'b11, 32'h3333_3333);
        req(0, 0, 2'b01, 2'b11, 2'b11, 32'h1);
        idle(1);

        // Reset while refilling beat 2 of way 1.
        next_cycle();
        rd = 1'b1; wr = 1'b0; hit_way = 2'b00; valid = 2'b01; md = 2'b00;
        ram_ack = 1'b0; exp_vec = '0;
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            ram_ack = 1'b1;
            exp_vec = mkv(1, b, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        end
        next_cycle();
        ram_ack = 1'b1;
        #1 chk("fill_beat2_lit", 16'({word_sel, wrd, wrt, rdram}), 16'b10101);
        exp_en  = 1'b0;
        reset_n = 1'b0;
        #1 chk("abort_outputs_zero", 16'(dut_vec), 16'h0);
        chk("abort_no_wrt", 16'(wrt), 16'h0);
        rd = 1'b0; ram_ack = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        rr_m = 0;
        idle(2);

        req(0, 0, 2'b00, 2'b11, 2'b00, 32'hFFFF_FFFF);
        #1 chk("post_reset_rr_lit", 16'({ack, way_sel}), 16'b10);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
